vga_timing_gen: RTL



---
 rtl/vga_timing_gen_if.sv | 21 ++
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel request/return bus between the timing generator
// and the framebuffer/renderer that supplies colour one clock later.
interface vga_timing_gen_if #(
  parameter int CW  = 12,
  parameter int BPC = 4
);
  logic             req;
  logic [CW-1:0]    x;
  logic [CW-1:0]    y;
  logic [3*BPC-1:0] pixel;

  modport master (
    output req, x, y,
    input  pixel
  );

  modport slave (
    input  req, x, y,
    output pixel
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with a 2-clock pixel pipe.
// Optional colour-bar test pattern: define VGA_TIMING_GEN_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 12,
  parameter int BPC      = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  input  logic           i_pattern,
  vga_timing_gen_if.master pix,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_de,
  output logic [BPC-1:0] o_red,
  output logic [BPC-1:0] o_green,
  output logic [BPC-1:0] o_blue,
  output logic           o_frame_start,
  output logic [7:0]     o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]    h_cnt_q, h_cnt_d;
  logic [CW-1:0]    v_cnt_q, v_cnt_d;
  logic             run, vis_s0, hs_s0, vs_s0, fs_s0;
  logic             vis1_q, vis1_d, hs1_q, hs1_d;
  logic             vs1_q, vs1_d, fs1_q, fs1_d;
  logic             de_q, de_d, fs_q, fs_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic [3*BPC-1:0] rgb_q, rgb_d, src_pix;
  logic [7:0]       fcnt_q, fcnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (i_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Request is also gated by reset so nothing is asked for while held.
  always_comb begin
    run    = i_en & i_rst_n;
    vis_s0 = run && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_s0  = run && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_s0  = run && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    fs_s0  = run && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  assign pix.req = vis_s0;
  assign pix.x   = vis_s0 ? h_cnt_q : '0;
  assign pix.y   = vis_s0 ? v_cnt_q : '0;

`ifdef VGA_TIMING_GEN_TEST_PATTERN_EN
  logic [CW-1:0] x1_q;
  logic [CW+2:0] x8;
  logic [2:0]    bar;
  logic [BPC-1:0] r_bar, g_bar, b_bar;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) x1_q <= '0;
    else          x1_q <= pix.x;
  end

  // Bars: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    x8      = {x1_q, 3'b000};
    bar     = 3'(x8 / (CW+3)'(H_ACTIVE));
    r_bar   = {BPC{~bar[1]}};
    g_bar   = {BPC{~bar[2]}};
    b_bar   = {BPC{~bar[0]}};
    src_pix = i_pattern ? {r_bar, g_bar, b_bar} : pix.pixel;
  end
`else
  logic unused_pattern;
  assign unused_pattern = i_pattern;
  assign src_pix        = pix.pixel;
`endif

  always_comb begin
    vis1_d  = vis_s0;
    hs1_d   = hs_s0;
    vs1_d   = vs_s0;
    fs1_d   = fs_s0;
    de_d    = vis1_q;
    fs_d    = fs1_q;
    hsync_d = hs1_q ? H_POL : ~H_POL;
    vsync_d = vs1_q ? V_POL : ~V_POL;
    rgb_d   = vis1_q ? src_pix : '0;
    fcnt_d  = fs1_q ? fcnt_q + 8'd1 : fcnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      rgb_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      vis1_q  <= vis1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_de          = de_q;
  assign o_red         = rgb_q[3*BPC-1:2*BPC];
  assign o_green       = rgb_q[2*BPC-1:BPC];
  assign o_blue        = rgb_q[BPC-1:0];
  assign o_frame_start = fs_q;
  assign o_frame_cnt   = fcnt_q;

endmodule
